// File: rtl/axil_fifo_frontend.sv
// AXI4-Lite slave front end for the SDRAM command FIFOs: holds single-beat writes and
// reads, pushes them into shared FIFOs in a fair order and returns popped read data.
module axil_fifo_frontend #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_BYTES_LOG2 = 25
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,

  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,

  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,

  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,

  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,

  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,

  output logic                  WADDR_FIFO_WR_EN,
  output logic [ADDR_WIDTH-1:0] WADDR_FIFO_DIN,
  input  logic                  WADDR_FIFO_FULL,

  output logic                  WDATA_FIFO_WR_EN,
  output logic [DATA_WIDTH-1:0] WDATA_FIFO_DIN,
  input  logic                  WDATA_FIFO_FULL,

  output logic                  RADDR_FIFO_WR_EN,
  output logic [ADDR_WIDTH-1:0] RADDR_FIFO_DIN,
  input  logic                  RADDR_FIFO_FULL,

  output logic                  RW_FIFO_WR_EN,
  output logic                  RW_FIFO_DIN,
  input  logic                  RW_FIFO_FULL,

  output logic                  RDATA_FIFO_RD_EN,
  input  logic [DATA_WIDTH-1:0] RDATA_FIFO_DOUT,
  input  logic                  RDATA_FIFO_EMPTY
);

  typedef enum logic [2:0] {
    R_IDLE,
    R_HOLD,
    R_WAIT,
    R_POP,
    R_RESP
  } rd_state_t;

  localparam logic [ADDR_WIDTH-1:0] SPAN_MASK =
    ADDR_WIDTH'((64'd1 << MEM_BYTES_LOG2) - 64'd1);

  // Byte address -> x16 half-word index of the containing 32-bit word.
  function automatic logic [ADDR_WIDTH-1:0] to_fifo_addr(input logic [ADDR_WIDTH-1:0] addr);
    return ((addr & SPAN_MASK) >> 2) << 1;
  endfunction

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> MEM_BYTES_LOG2) != '0;
  endfunction

  logic                  aw_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data;
  logic [3:0]            w_strb;
  logic                  wr_prio;
  logic [ADDR_WIDTH-1:0] ar_addr;
  rd_state_t             rd_state;

  logic wr_pair;
  logic wr_bad_addr;
  logic wr_bad_strb;
  logic wr_elig;
  logic wr_err_issue;
  logic rd_elig;
  logic wr_go;
  logic rd_go;
  logic wr_done;
  logic aw_load;
  logic w_load;
  logic aw_full_nxt;
  logic w_full_nxt;

  // A pending RW push blocks the next one so FULL is always sampled after it lands.
  assign wr_pair      = aw_full && w_full && !BVALID;
  assign wr_bad_addr  = out_of_range(aw_addr);
  assign wr_bad_strb  = (w_strb != 4'hF);
  assign wr_elig      = wr_pair && !wr_bad_addr && !wr_bad_strb && !WADDR_FIFO_FULL &&
                        !WDATA_FIFO_FULL && !RW_FIFO_FULL && !RW_FIFO_WR_EN;
  assign wr_err_issue = wr_pair && (wr_bad_addr || wr_bad_strb);
  assign rd_elig      = (rd_state == R_HOLD) && !out_of_range(ar_addr) &&
                        !RADDR_FIFO_FULL && !RW_FIFO_FULL && !RW_FIFO_WR_EN;
  assign wr_go        = wr_elig && (!rd_elig || wr_prio);
  assign rd_go        = rd_elig && (!wr_elig || !wr_prio);
  assign wr_done      = wr_go || wr_err_issue;
  assign aw_load      = AWVALID && AWREADY;
  assign w_load       = WVALID && WREADY;
  assign aw_full_nxt  = aw_load || (aw_full && !wr_done);
  assign w_full_nxt   = w_load || (w_full && !wr_done);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_full          <= 1'b0;
      aw_addr          <= '0;
      w_full           <= 1'b0;
      w_data           <= '0;
      w_strb           <= '0;
      AWREADY          <= 1'b0;
      WREADY           <= 1'b0;
      BVALID           <= 1'b0;
      BRESP            <= 2'b00;
      WADDR_FIFO_WR_EN <= 1'b0;
      WADDR_FIFO_DIN   <= '0;
      WDATA_FIFO_WR_EN <= 1'b0;
      WDATA_FIFO_DIN   <= '0;
    end else begin
      aw_full          <= aw_full_nxt;
      w_full           <= w_full_nxt;
      AWREADY          <= !aw_full_nxt;
      WREADY           <= !w_full_nxt;
      WADDR_FIFO_WR_EN <= wr_go;
      WDATA_FIFO_WR_EN <= wr_go;
      if (aw_load) begin
        aw_addr <= AWADDR;
      end
      if (w_load) begin
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      if (wr_go) begin
        WADDR_FIFO_DIN <= to_fifo_addr(aw_addr);
        WDATA_FIFO_DIN <= w_data;
      end
      if (wr_done) begin
        BVALID <= 1'b1;
        BRESP  <= wr_bad_addr ? 2'b11 : (wr_bad_strb ? 2'b10 : 2'b00);
      end else if (BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  // Round-robin only on contention: the loser of the last tie gets the next one.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      RW_FIFO_WR_EN <= 1'b0;
      RW_FIFO_DIN   <= 1'b0;
      wr_prio       <= 1'b1;
    end else begin
      RW_FIFO_WR_EN <= wr_go || rd_go;
      if (wr_go) begin
        RW_FIFO_DIN <= 1'b1;
      end else if (rd_go) begin
        RW_FIFO_DIN <= 1'b0;
      end
      if (wr_elig && rd_elig) begin
        wr_prio <= !wr_prio;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state         <= R_IDLE;
      ar_addr          <= '0;
      ARREADY          <= 1'b0;
      RADDR_FIFO_WR_EN <= 1'b0;
      RADDR_FIFO_DIN   <= '0;
      RDATA_FIFO_RD_EN <= 1'b0;
      RDATA            <= '0;
      RRESP            <= 2'b00;
      RVALID           <= 1'b0;
    end else begin
      RADDR_FIFO_WR_EN <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            ar_addr  <= ARADDR;
            ARREADY  <= 1'b0;
            rd_state <= R_HOLD;
          end else begin
            ARREADY  <= 1'b1;
          end
        end
        R_HOLD: begin
          if (out_of_range(ar_addr)) begin
            RDATA    <= '0;
            RRESP    <= 2'b11;
            RVALID   <= 1'b1;
            rd_state <= R_RESP;
          end else if (rd_go) begin
            RADDR_FIFO_WR_EN <= 1'b1;
            RADDR_FIFO_DIN   <= to_fifo_addr(ar_addr);
            rd_state         <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (!RDATA_FIFO_EMPTY) begin
            RDATA_FIFO_RD_EN <= 1'b1;
            rd_state         <= R_POP;
          end
        end
        // First cycle here the FIFO consumes RD_EN; DOUT is valid on the next one.
        R_POP: begin
          if (RDATA_FIFO_RD_EN) begin
            RDATA_FIFO_RD_EN <= 1'b0;
          end else begin
            RDATA    <= RDATA_FIFO_DOUT;
            RRESP    <= 2'b00;
            RVALID   <= 1'b1;
            rd_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            RVALID   <= 1'b0;
            ARREADY  <= 1'b1;
            rd_state <= R_IDLE;
          end
        end
        default: begin
          rd_state <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_fifo_frontend.sv
// Directed self-checking bench for axil_fifo_frontend: FIFO side is driven by hand and
// every push is logged on the falling edge.
module tb_axil_fifo_frontend;

   logic        aclk = 1'b0;
   logic        aresetN;
   logic [31:0] awAddr;
   logic        awValid;
   logic        awReady;
   logic [31:0] wData;
   logic [3:0]  wStrb;
   logic        wValid;
   logic        wReady;
   logic [1:0]  bResp;
   logic        bValid;
   logic        bReady;
   logic [31:0] arAddr;
   logic        arValid;
   logic        arReady;
   logic [31:0] rData;
   logic [1:0]  rResp;
   logic        rValid;
   logic        rReady;
   logic        waddrEn;
   logic [31:0] waddrDin;
   logic        waddrFull;
   logic        wdataEn;
   logic [31:0] wdataDin;
   logic        wdataFull;
   logic        raddrEn;
   logic [31:0] raddrDin;
   logic        raddrFull;
   logic        rwEn;
   logic        rwDin;
   logic        rwFull;
   logic        rdEn;
   logic [31:0] rdataDout;
   logic        rdataEmpty;

   int          numCompared = 0;
   int          numMismatched = 0;
   int          waddrCnt = 0;
   int          raddrCnt = 0;
   int          rdEnCnt = 0;
   logic [31:0] lastWaddr = '0;
   logic [31:0] lastWdata = '0;
   logic [31:0] lastRaddr = '0;
   logic        rwLog[$];

   // Free-running 100 MHz clock
   always #5 aclk = ~aclk;

   axil_fifo_frontend #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .MEM_BYTES_LOG2(25)
   ) dut (
      .ACLK(aclk),
      .ARESETn(aresetN),
      .AWADDR(awAddr),
      .AWVALID(awValid),
      .AWREADY(awReady),
      .WDATA(wData),
      .WSTRB(wStrb),
      .WVALID(wValid),
      .WREADY(wReady),
      .BRESP(bResp),
      .BVALID(bValid),
      .BREADY(bReady),
      .ARADDR(arAddr),
      .ARVALID(arValid),
      .ARREADY(arReady),
      .RDATA(rData),
      .RRESP(rResp),
      .RVALID(rValid),
      .RREADY(rReady),
      .WADDR_FIFO_WR_EN(waddrEn),
      .WADDR_FIFO_DIN(waddrDin),
      .WADDR_FIFO_FULL(waddrFull),
      .WDATA_FIFO_WR_EN(wdataEn),
      .WDATA_FIFO_DIN(wdataDin),
      .WDATA_FIFO_FULL(wdataFull),
      .RADDR_FIFO_WR_EN(raddrEn),
      .RADDR_FIFO_DIN(raddrDin),
      .RADDR_FIFO_FULL(raddrFull),
      .RW_FIFO_WR_EN(rwEn),
      .RW_FIFO_DIN(rwDin),
      .RW_FIFO_FULL(rwFull),
      .RDATA_FIFO_RD_EN(rdEn),
      .RDATA_FIFO_DOUT(rdataDout),
      .RDATA_FIFO_EMPTY(rdataEmpty)
   );

   // Log every FIFO push/pop on the falling edge, one entry per cycle of enable
   always @(negedge aclk) begin
      if (waddrEn) begin
         waddrCnt++;
         lastWaddr = waddrDin;
      end
      if (wdataEn) begin
         lastWdata = wdataDin;
      end
      if (raddrEn) begin
         raddrCnt++;
         lastRaddr = raddrDin;
      end
      if (rwEn) begin
         rwLog.push_back(rwDin);
      end
      if (rdEn) begin
         rdEnCnt++;
      end
   end

   // Single comparison point: counts and reports every check
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      numCompared++;
      if (actual !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Present AW/W and/or AR together and drop each valid after its handshake edge
   task automatic applyStimulus(input bit doWr, input bit doRd, input logic [31:0] wAddrIn,
                                input logic [31:0] wDataIn, input logic [3:0] strbIn,
                                input logic [31:0] rAddrIn);
      bit awHs;
      bit wHs;
      bit arHs;
      @(posedge aclk);
      #1;
      awAddr  = wAddrIn;
      awValid = doWr;
      wData   = wDataIn;
      wStrb   = strbIn;
      wValid  = doWr;
      arAddr  = rAddrIn;
      arValid = doRd;
      for (int i = 0; i < 40 && (awValid || wValid || arValid); i++) begin
         @(negedge aclk);
         awHs = awValid && awReady;
         wHs  = wValid && wReady;
         arHs = arValid && arReady;
         @(posedge aclk);
         #1;
         if (awHs) awValid = 1'b0;
         if (wHs)  wValid  = 1'b0;
         if (arHs) arValid = 1'b0;
      end
      checkOutput("handshake", {29'd0, awValid, wValid, arValid}, 32'd0);
      awValid = 1'b0;
      wValid  = 1'b0;
      arValid = 1'b0;
   endtask

   // Make read data available, retire the single pop and check the returned beat
   task automatic serveRead(input logic [31:0] value);
      bit seen;
      seen = 1'b0;
      rdataDout  = value;
      rdataEmpty = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (rdEn) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("rdEnSeen", 32'(seen), 32'd1);
      @(posedge aclk);
      #1;
      rdataEmpty = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (rValid) break;
      end
      checkOutput("rValid", 32'(rValid), 32'd1);
      checkOutput("rData", rData, value);
      checkOutput("rResp", 32'(rResp), 32'd0);
      @(posedge aclk);
      #1;
   endtask

   initial begin
      bit seen;
      aresetN    = 1'b0;
      awAddr     = '0;
      awValid    = 1'b0;
      wData      = '0;
      wStrb      = '0;
      wValid     = 1'b0;
      bReady     = 1'b1;
      arAddr     = '0;
      arValid    = 1'b0;
      rReady     = 1'b1;
      waddrFull  = 1'b0;
      wdataFull  = 1'b0;
      raddrFull  = 1'b0;
      rwFull     = 1'b0;
      rdataDout  = '0;
      rdataEmpty = 1'b1;

      // Reset state and ready rise one edge after release
      repeat (2) @(negedge aclk);
      checkOutput("rstReadies", {29'd0, awReady, wReady, arReady}, 32'd0);
      checkOutput("rstValids", {30'd0, bValid, rValid}, 32'd0);
      checkOutput("rstEnables", {27'd0, waddrEn, wdataEn, raddrEn, rwEn, rdEn}, 32'd0);
      @(posedge aclk);
      #1;
      aresetN = 1'b1;
      @(negedge aclk);
      checkOutput("awReadyBeforeEdge", 32'(awReady), 32'd0);
      @(negedge aclk);
      checkOutput("readiesAfterEdge", {29'd0, awReady, wReady, arReady}, 32'd7);

      // Basic write: pushes and BVALID one edge after the handshake edge
      applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
      @(negedge aclk);
      checkOutput("t1NoEarlyPush", 32'(waddrEn), 32'd0);
      @(negedge aclk);
      checkOutput("t1WaddrEn", 32'(waddrEn), 32'd1);
      checkOutput("t1WaddrDin", waddrDin, 32'h0000_0008);
      checkOutput("t1WdataEn", 32'(wdataEn), 32'd1);
      checkOutput("t1WdataDin", wdataDin, 32'hDEAD_BEEF);
      checkOutput("t1Rw", {30'd0, rwEn, rwDin}, 32'd3);
      checkOutput("t1BValid", 32'(bValid), 32'd1);
      checkOutput("t1BResp", 32'(bResp), 32'd0);
      @(negedge aclk);
      checkOutput("t1PulseEnds", {30'd0, waddrEn, bValid}, 32'd0);
      checkOutput("t1WaddrCnt", 32'(waddrCnt), 32'd1);

      // W three cycles ahead of AW: held, single push once AW lands
      @(posedge aclk);
      #1;
      wData  = 32'h1234_5678;
      wStrb  = 4'hF;
      wValid = 1'b1;
      @(negedge aclk);
      checkOutput("t2WReady", 32'(wReady), 32'd1);
      @(posedge aclk);
      #1;
      wValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         checkOutput("t2WReadyLow", 32'(wReady), 32'd0);
         checkOutput("t2NoPush", 32'(waddrEn), 32'd0);
      end
      @(posedge aclk);
      #1;
      awAddr  = 32'h0000_0020;
      awValid = 1'b1;
      @(negedge aclk);
      checkOutput("t2AwReady", 32'(awReady), 32'd1);
      @(posedge aclk);
      #1;
      awValid = 1'b0;
      @(negedge aclk);
      checkOutput("t2StillHeld", {30'd0, wReady, waddrEn}, 32'd0);
      @(negedge aclk);
      checkOutput("t2Push", 32'(waddrEn), 32'd1);
      checkOutput("t2WaddrDin", waddrDin, 32'h0000_0010);
      checkOutput("t2WdataDin", wdataDin, 32'h1234_5678);
      checkOutput("t2WReadyBack", 32'(wReady), 32'd1);
      repeat (2) @(negedge aclk);
      checkOutput("t2WaddrCnt", 32'(waddrCnt), 32'd2);

      // Read with data arriving five cycles later
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0000_0010);
      @(negedge aclk);
      checkOutput("t3NoEarlyPush", 32'(raddrEn), 32'd0);
      @(negedge aclk);
      checkOutput("t3RaddrEn", 32'(raddrEn), 32'd1);
      checkOutput("t3RaddrDin", raddrDin, 32'h0000_0008);
      checkOutput("t3Rw", {30'd0, rwEn, rwDin}, 32'd2);
      repeat (5) @(posedge aclk);
      #1;
      serveRead(32'hCAFE_F00D);
      repeat (2) @(negedge aclk);
      checkOutput("t3RdEnCnt", 32'(rdEnCnt), 32'd1);
      checkOutput("t3RaddrCnt", 32'(raddrCnt), 32'd1);

      // Error responses: decode error, partial strobe, out-of-range read
      applyStimulus(1'b1, 1'b0, 32'h0200_0000, 32'h5555_5555, 4'hF, 32'h0);
      repeat (2) @(negedge aclk);
      checkOutput("t4DecBValid", 32'(bValid), 32'd1);
      checkOutput("t4DecBResp", 32'(bResp), 32'd3);
      applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h6666_6666, 4'h3, 32'h0);
      repeat (2) @(negedge aclk);
      checkOutput("t4SlvBValid", 32'(bValid), 32'd1);
      checkOutput("t4SlvBResp", 32'(bResp), 32'd2);
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0400_0000);
      repeat (2) @(negedge aclk);
      checkOutput("t4RdValid", 32'(rValid), 32'd1);
      checkOutput("t4RdResp", 32'(rResp), 32'd3);
      checkOutput("t4RdData", rData, 32'h0);
      repeat (3) @(negedge aclk);
      checkOutput("t4NoWrPush", 32'(waddrCnt), 32'd2);
      checkOutput("t4NoRdPush", 32'(raddrCnt), 32'd1);

      // Contention twice: first tie to the write, second to the read
      rwLog.delete();
      applyStimulus(1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'hF, 32'h0000_0200);
      repeat (6) @(negedge aclk);
      checkOutput("t5aLogSize", 32'(rwLog.size()), 32'd2);
      if (rwLog.size() == 2) begin
         checkOutput("t5aOrder", {30'd0, rwLog[0], rwLog[1]}, 32'd2);
      end
      checkOutput("t5aWaddr", lastWaddr, 32'h0000_0080);
      checkOutput("t5aRaddr", lastRaddr, 32'h0000_0100);
      serveRead(32'h1111_1111);
      rwLog.delete();
      applyStimulus(1'b1, 1'b1, 32'h0000_0300, 32'h5A5A_5A5A, 4'hF, 32'h0000_0400);
      repeat (6) @(negedge aclk);
      checkOutput("t5bLogSize", 32'(rwLog.size()), 32'd2);
      if (rwLog.size() == 2) begin
         checkOutput("t5bOrder", {30'd0, rwLog[0], rwLog[1]}, 32'd1);
      end
      checkOutput("t5bWdata", lastWdata, 32'h5A5A_5A5A);
      serveRead(32'h2222_2222);
      checkOutput("t5RdEnCnt", 32'(rdEnCnt), 32'd3);

      // RW FIFO full holds the write until released
      rwFull = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0BAD_F00D, 4'hF, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         checkOutput("t6NoPush", {30'd0, waddrEn, bValid}, 32'd0);
         checkOutput("t6AwReadyLow", 32'(awReady), 32'd0);
      end
      @(posedge aclk);
      #1;
      rwFull = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         if (waddrEn) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("t6PushSeen", 32'(seen), 32'd1);
      checkOutput("t6BValid", 32'(bValid), 32'd1);
      checkOutput("t6WdataDin", wdataDin, 32'h0BAD_F00D);
      repeat (2) @(negedge aclk);
      checkOutput("t6WaddrCnt", 32'(waddrCnt), 32'd5);

      // Reset while the read waits for data
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0000_0080);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         if (raddrEn) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("t7RaddrSeen", 32'(seen), 32'd1);
      #1;
      aresetN = 1'b0;
      #1;
      checkOutput("t7RaddrEnCleared", 32'(raddrEn), 32'd0);
      checkOutput("t7RaddrDinCleared", raddrDin, 32'h0);
      checkOutput("t7RwCleared", {30'd0, rwEn, rwDin}, 32'd0);
      checkOutput("t7ReadiesCleared", {29'd0, awReady, wReady, arReady}, 32'd0);
      checkOutput("t7OutputsCleared", {30'd0, bValid, rValid}, 32'd0);
      @(posedge aclk);
      #1;
      aresetN = 1'b1;
      @(negedge aclk);
      checkOutput("t7ArReadyBeforeEdge", 32'(arReady), 32'd0);
      @(negedge aclk);
      checkOutput("t7ArReadyAfterEdge", 32'(arReady), 32'd1);
      checkOutput("t7RaddrCnt", 32'(raddrCnt), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
